int_array_requantize: RTL and testbench

Pipelined requantizer that sits directly downstream of the integer entrywise-product stage. It takes each full-precision signed product array and applies a per-beat arithmetic right shift with round-half-up. It then saturates every element to a narrower signed width and forwards the array under a valid/ready handshake. The block also exposes a per-beat saturation flag and a sticky, saturating event counter for range monitoring.

---
 rtl/int_array_requantize.sv | 150 +++++++++++++++
 tb/tb_int_array_requantize.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_array_requantize.sv
// rtl/int_array_requantize.sv - two-stage round/saturate requantizer for signed product arrays
//
// Purpose: take a full-precision signed array beat, arithmetic-right-shift each
// element with round-half-up, clamp to OUT_WIDTH signed, and forward under a
// valid/ready handshake. Also counts accepted beats that had any clamped element.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   in_i[DIM]    signed IN_WIDTH input elements
//   shift_i      right-shift amount, sampled with in_i on acceptance
//   in_valid_i   input beat valid
//   in_ready_o   block can accept a beat this cycle
//   out_o[DIM]   signed OUT_WIDTH requantized elements
//   out_sat_o    at least one element of the current output beat was clamped
//   out_valid_o  output beat valid
//   out_ready_i  downstream accepts
//   sat_clr_i    synchronous clear of sat_count_o (wins over an increment)
//   sat_count_o  accepted beats with out_sat_o=1, saturating at 0xFFFF
module int_array_requantize #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int DIM         = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic signed [IN_WIDTH-1:0]  in_i [DIM],
    input  logic [SHIFT_WIDTH-1:0]      shift_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic signed [OUT_WIDTH-1:0] out_o [DIM],
    output logic                        out_sat_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    input  logic                        sat_clr_i,
    output logic [15:0]                 sat_count_o
);

    // One extra bit so the rounding bias add can never overflow.
    localparam int          RW     = IN_WIDTH + 1;
    localparam int unsigned MAX_SH = IN_WIDTH - 1;

    logic signed [RW-1:0]        r_d [DIM];
    logic signed [RW-1:0]        r_q [DIM];
    logic                        s1_valid_d, s1_valid_q;

    logic signed [OUT_WIDTH-1:0] out_d [DIM];
    logic signed [OUT_WIDTH-1:0] out_q [DIM];
    logic                        out_sat_d, out_sat_q;
    logic                        out_valid_d, out_valid_q;

    logic [15:0]                 sat_count_d, sat_count_q;

    logic                        en1, en2;
    logic [SHIFT_WIDTH-1:0]      s_eff;

    // Stage enables: a stage may load when it is empty or its contents move on.
    assign en2        = !out_valid_q || out_ready_i;
    assign en1        = !s1_valid_q || en2;
    assign in_ready_o = en1;

    // Shifting by IN_WIDTH-1 already reduces any input to -1, 0 or 1, so
    // larger shifts are clamped rather than handled separately.
    always_comb begin
        s_eff = shift_i;
        if (32'(shift_i) > MAX_SH) begin
            s_eff = SHIFT_WIDTH'(MAX_SH);
        end
    end

    // Stage 1: round-half-up right shift, per element.
    always_comb begin
        logic signed [RW-1:0] xe;
        logic signed [RW-1:0] bias;
        xe   = '0;
        bias = '0;
        for (int i = 0; i < DIM; i++) begin
            xe = {in_i[i][IN_WIDTH-1], in_i[i]};
            if (s_eff == '0) begin
                bias = '0;
            end else begin
                bias = RW'(1) << (s_eff - 1'b1);
            end
            r_d[i] = (xe + bias) >>> s_eff;
        end
        s1_valid_d = in_valid_i;
    end

    // Stage 2: clamp to OUT_WIDTH. A value fits when all bits from the output
    // sign bit upward agree; otherwise its true sign picks the rail.
    always_comb begin
        logic [RW-OUT_WIDTH:0] hi;
        hi        = '0;
        out_sat_d = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            hi = r_q[i][RW-1:OUT_WIDTH-1];
            if ((&hi) || !(|hi)) begin
                out_d[i] = r_q[i][OUT_WIDTH-1:0];
            end else begin
                out_sat_d = 1'b1;
                if (r_q[i][RW-1]) begin
                    out_d[i] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                end else begin
                    out_d[i] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end
        end
        out_valid_d = s1_valid_q;
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr_i) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready_i && out_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DIM; i++) begin
                r_q[i]   <= '0;
                out_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sat_count_q <= '0;
        end else begin
            if (en1) begin
                r_q        <= r_d;
                s1_valid_q <= s1_valid_d;
            end
            if (en2) begin
                out_q       <= out_d;
                out_sat_q   <= out_sat_d;
                out_valid_q <= out_valid_d;
            end
            sat_count_q <= sat_count_d;
        end
    end

    assign out_o       = out_q;
    assign out_sat_o   = out_sat_q;
    assign out_valid_o = out_valid_q;
    assign sat_count_o = sat_count_q;

endmodule

// File: tb/tb_int_array_requantize.sv
// tb/tb_int_array_requantize.sv - self-checking bench for int_array_requantize
module tb_int_array_requantize;

    localparam int IW = 16;
    localparam int OW = 8;
    localparam int D  = 8;
    localparam int SW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [IW-1:0] in_d [D];
    logic [SW-1:0]        shift;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [OW-1:0] out_d [D];
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sat_clr;
    logic [15:0]          sat_count;

    always #5 clk = ~clk;

    int_array_requantize #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DIM(D), .SHIFT_WIDTH(SW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in_d), .shift_i(shift),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .out_o(out_d),
        .out_sat_o(out_sat), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sat_clr_i(sat_clr), .sat_count_o(sat_count)
    );

    typedef struct {
        int o[D];
        bit sat;
        int cyc;
    } beat_t;

    typedef struct {
        int x[D];
        int sh;
        int o[D];
        bit sat;
    } vec_t;

    beat_t q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    model_cnt = 0;
    int    last_o[D];
    bit    last_sat;
    int    last_lat;
    bit    popped;
    bit    accepted;
    int    npop = 0;
    bit    prev_hold = 0;
    int    prev_o[D];
    bit    prev_sat;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: floor division of (x + half) by 2^s, then clamp.
    task automatic model_elem(input int x, input int sh, output int o, output bit c);
        longint s, num, d, r;
        s = (sh > IW - 1) ? IW - 1 : sh;
        if (s == 0) begin
            r = x;
        end else begin
            d   = longint'(1) << s;
            num = longint'(x) + d / 2;
            r   = (num >= 0) ? num / d : -((-num + d - 1) / d);
        end
        c = 1'b0;
        if (r > 127) begin
            r = 127; c = 1'b1;
        end else if (r < -128) begin
            r = -128; c = 1'b1;
        end
        o = int'(r);
    endtask

    task automatic model_beat(output beat_t b);
        bit c;
        b.sat = 1'b0;
        for (int i = 0; i < D; i++) begin
            model_elem(int'(in_d[i]), int'(shift), b.o[i], c);
            b.sat = b.sat | c;
        end
        b.cyc = cyc;
    endtask

    // One clock: called at a falling edge after inputs are set.
    task automatic tick();
        beat_t b;
        bit    hs_out;
        bit    exp_sat;
        #1;
        check("in_ready", int'(in_ready), int'(!(q.size() == 2 && !out_ready)));
        if (prev_hold) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_sat", int'(out_sat), int'(prev_sat));
            for (int i = 0; i < D; i++) check("hold_out", int'(out_d[i]), prev_o[i]);
        end
        hs_out  = out_valid && out_ready;
        exp_sat = 1'b0;
        popped  = 1'b0;
        if (out_valid && q.size() == 0) begin
            check("spurious_valid", 1, 0);
        end else if (hs_out) begin
            b = q.pop_front();
            for (int i = 0; i < D; i++) check("out_elem", int'(out_d[i]), b.o[i]);
            check("out_sat", int'(out_sat), int'(b.sat));
            exp_sat  = b.sat;
            last_o   = b.o;
            for (int i = 0; i < D; i++) last_o[i] = int'(out_d[i]);
            last_sat = out_sat;
            last_lat = cyc - b.cyc;
            popped   = 1'b1;
            npop++;
        end
        if (sat_clr) model_cnt = 0;
        else if (hs_out && exp_sat && model_cnt < 65535) model_cnt++;
        prev_hold = out_valid && !out_ready;
        for (int i = 0; i < D; i++) prev_o[i] = int'(out_d[i]);
        prev_sat = out_sat;
        accepted = in_valid && in_ready;
        if (accepted) begin
            model_beat(b);
            q.push_back(b);
        end
        @(negedge clk);
        cyc++;
        check("sat_count", int'(sat_count), model_cnt);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < D; i++) in_d[i] = IW'(v.x[i]);
        shift = SW'(v.sh);
    endtask

    task automatic fill_const(input int x, input int sh);
        for (int i = 0; i < D; i++) in_d[i] = IW'(x);
        shift = SW'(sh);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < D; i++) in_d[i] = IW'($urandom_range(0, 65535));
        shift = SW'($urandom_range(0, 31));
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    vec_t tab[3];

    initial begin
        tab[0] = '{x: '{120, 24, -24, -8, 7, 0, -1, 8}, sh: 4,
                   o: '{8, 2, -1, 0, 0, 0, 0, 1}, sat: 1'b0};
        tab[1] = '{x: '{4000, -4000, 508, 511, -512, -516, 0, 0}, sh: 2,
                   o: '{127, -128, 127, 127, -128, -128, 0, 0}, sat: 1'b1};
        tab[2] = '{x: '{-32768, 32767, 16384, 16383, 0, -1, 1, -16384}, sh: 31,
                   o: '{-1, 1, 1, 0, 0, 0, 0, 0}, sat: 1'b0};

        in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        fill_const(0, 0);

        // Reset state
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out0", int'(out_d[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table vectors with exact latency
        for (int t = 0; t < 3; t++) begin
            load_vec(tab[t]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 10 && !popped; k++) tick();
            if (!popped) check("tab_timeout", 0, 1);
            for (int i = 0; i < D; i++) check("tab_out", last_o[i], tab[t].o[i]);
            check("tab_sat", int'(last_sat), int'(tab[t].sat));
            check("tab_latency", last_lat, 2);
        end
        check("sat_count_after_tab", int'(sat_count), 1);

        // Backpressure: 5 beats, out_ready low during cycles 3..7
        begin
            int sent;
            bit saw_low;
            sent = 0; saw_low = 1'b0; npop = 0;
            for (int k = 0; k < 40; k++) begin
                out_ready = !(k >= 3 && k <= 7);
                in_valid  = (sent < 5);
                fill_rand();
                if (k >= 3 && k <= 7 && !in_ready) saw_low = 1'b1;
                tick();
                if (accepted) sent++;
            end
            check("bp_in_ready_drop", int'(saw_low), 1);
            check("bp_delivered", npop, 5);
            check("bp_queue_empty", q.size(), 0);
        end

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 31) == 0);
            fill_rand();
            tick();
        end
        sat_clr = 1'b0;
        drain(5);
        check("rand_queue_empty", q.size(), 0);

        // Counter saturation: 0xFFFF+3 saturating beats
        begin
            int sent;
            sent = 0;
            sat_clr = 1'b1;
            tick();
            sat_clr = 1'b0;
            fill_const(4000, 0);
            out_ready = 1'b1;
            for (int k = 0; k < 70000 && sent < 65538; k++) begin
                in_valid = 1'b1;
                tick();
                if (accepted) sent++;
            end
            check("cnt_sent", sent, 65538);
            drain(5);
            check("cnt_hold_ffff", int'(sat_count), 65535);
        end

        // sat_clr in the same cycle as a saturating handshake
        fill_const(-4000, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !popped; k++) begin
            sat_clr = out_valid;
            tick();
        end
        sat_clr = 1'b0;
        check("clr_priority", int'(sat_count), 0);

        // Reset mid-stream with both stages full
        fill_const(30000, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !popped; k++) tick();
        check("pre_rst_count", int'(sat_count), 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("pre_rst_full", int'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_sat_count", int'(sat_count), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        q.delete();
        model_cnt = 0;
        prev_hold = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        load_vec(tab[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !popped; k++) tick();
        if (!popped) check("post_rst_timeout", 0, 1);
        check("post_rst_latency", last_lat, 2);
        check("post_rst_out0", last_o[0], 8);
        drain(3);
        check("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
